// File: rtl/xfer_pkg.sv
// xfer_pkg: shared types and constants for the CHIP-8 memory transfer engine
package xfer_pkg;
   typedef enum logic [1:0] {XFER_STORE = 2'd0, XFER_LOAD = 2'd1, XFER_BCD = 2'd2} xfer_op_t;
   typedef enum logic [2:0] {IDLE, ST_WR, LD_RUN, BCD_RD, BCD_WR, FINISH, DONE} xfer_state_t;
   localparam int BCD_DW = 4;
   localparam int BCD_ND = 3;
   typedef logic [BCD_DW-1:0] bcd_digit_t;
endpackage

// File: rtl/mem_xfer_engine_if.sv
// mem_xfer_engine_if: execute-stage handshake, RAM ports and register-file ports of the engine
interface mem_xfer_engine_if #(parameter int AW = 12);
   logic start_in;
   logic [1:0] op_in;
   logic [3:0] x_in;
   logic [AW-1:0] i_in;
   logic busy_out;
   logic done_out;
   logic i_wr_en_out;
   logic [AW-1:0] i_next_out;
   logic mem_we_out;
   logic [AW-1:0] mem_wr_addr_out;
   logic [7:0] mem_wr_data_out;
   logic [AW-1:0] mem_rd_addr_out;
   logic [7:0] mem_rd_data_in;
   logic [3:0] reg_rd_idx_out;
   logic [7:0] reg_rd_data_in;
   logic reg_we_out;
   logic [3:0] reg_wr_idx_out;
   logic [7:0] reg_wr_data_out;
   modport master (
      input start_in, op_in, x_in, i_in, mem_rd_data_in, reg_rd_data_in,
      output busy_out, done_out, i_wr_en_out, i_next_out, mem_we_out, mem_wr_addr_out,
      mem_wr_data_out, mem_rd_addr_out, reg_rd_idx_out, reg_we_out, reg_wr_idx_out, reg_wr_data_out
   );
   modport slave (
      output start_in, op_in, x_in, i_in, mem_rd_data_in, reg_rd_data_in,
      input busy_out, done_out, i_wr_en_out, i_next_out, mem_we_out, mem_wr_addr_out,
      mem_wr_data_out, mem_rd_addr_out, reg_rd_idx_out, reg_we_out, reg_wr_idx_out, reg_wr_data_out
   );
endinterface

// File: rtl/bcd_digits.sv
// bcd_digits: combinational 8-bit binary to hundreds/tens/ones by compare-and-subtract
module bcd_digits
   import xfer_pkg::*;
(
   input  logic [7:0] bin,
   output bcd_digit_t hun,
   output bcd_digit_t tens,
   output bcd_digit_t ones
);
   logic [7:0] r;
   always_comb begin
      hun = bin >= 8'd200 ? 4'd2 : bin >= 8'd100 ? 4'd1 : 4'd0;
      r = bin >= 8'd200 ? bin - 8'd200 : bin >= 8'd100 ? bin - 8'd100 : bin;
      tens = 4'd0;
      for (int t = 1; t < 10; t++) if (r >= 8'(10 * t)) tens = 4'(t);
      ones = 4'(r - 8'(10 * tens));
   end
endmodule

// File: rtl/mem_xfer_engine.sv
// mem_xfer_engine: multi-cycle sequencer for CHIP-8 FX55 / FX65 / FX33 register-memory transfers
module mem_xfer_engine
   import xfer_pkg::*;
#(
   parameter int RAM_SIZE_BYTES = 4096,
   parameter bit I_INCREMENT = 1'b0
) (
   input logic clk_in,
   input logic rst_n_in,
   mem_xfer_engine_if.master bus
);
   localparam int AW = $clog2(RAM_SIZE_BYTES);
   xfer_state_t state, nxt, entry;
   logic [1:0] op_q;
   logic [3:0] x_q;
   logic [AW-1:0] i_q;
   logic [4:0] k;
   logic [BCD_ND-1:0][BCD_DW-1:0] dig;
   bcd_digit_t h, t, o;
   logic accept, ld_rd;
   bcd_digits u_bcd (.bin(bus.reg_rd_data_in), .hun(h), .tens(t), .ones(o));
   // DONE behaves like IDLE for acceptance so operations can run back-to-back
   assign accept = bus.start_in && (state == IDLE || state == DONE);
   assign entry = bus.op_in == 2'(XFER_STORE) ? ST_WR :
                  bus.op_in == 2'(XFER_LOAD)  ? LD_RUN :
                  bus.op_in == 2'(XFER_BCD)   ? BCD_RD : FINISH;
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
         op_q <= '0;
         x_q <= '0;
         i_q <= '0;
         k <= '0;
         dig <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            op_q <= bus.op_in;
            x_q <= bus.x_in;
            i_q <= bus.i_in;
         end
         k <= accept ? 5'd0 : (state == ST_WR || state == LD_RUN || state == BCD_WR) ? k + 5'd1 : k;
         if (state == BCD_RD) dig <= {o, t, h};
      end
   end
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, DONE: nxt = bus.start_in ? entry : IDLE;
         ST_WR:      nxt = k == {1'b0, x_q} ? DONE : ST_WR;
         LD_RUN:     nxt = k == {1'b0, x_q} + 5'd1 ? DONE : LD_RUN;
         BCD_RD:     nxt = BCD_WR;
         BCD_WR:     nxt = k == 5'd2 ? DONE : BCD_WR;
         default:    nxt = DONE;
      endcase
   end
   // LOAD is pipelined: read address for k, register write of k-1
   assign ld_rd = state == LD_RUN && k != {1'b0, x_q} + 5'd1;
   always_comb begin
      bus.busy_out = state inside {ST_WR, LD_RUN, BCD_RD, BCD_WR, FINISH};
      bus.done_out = state == DONE;
      bus.i_wr_en_out = I_INCREMENT && state == DONE && (op_q == 2'(XFER_STORE) || op_q == 2'(XFER_LOAD));
      bus.i_next_out = bus.i_wr_en_out ? i_q + AW'(x_q) + AW'(1) : '0;
      bus.mem_we_out = state == ST_WR || state == BCD_WR;
      bus.mem_wr_addr_out = bus.mem_we_out ? i_q + AW'(k) : '0;
      bus.mem_wr_data_out = state == ST_WR ? bus.reg_rd_data_in :
                            state == BCD_WR ? {4'd0, dig[k[1:0]]} : '0;
      bus.mem_rd_addr_out = ld_rd ? i_q + AW'(k) : '0;
      bus.reg_rd_idx_out = state == ST_WR ? k[3:0] : state == BCD_RD ? x_q : '0;
      bus.reg_we_out = state == LD_RUN && k != 5'd0;
      bus.reg_wr_idx_out = bus.reg_we_out ? k[3:0] - 4'd1 : '0;
      bus.reg_wr_data_out = bus.reg_we_out ? bus.mem_rd_data_in : '0;
   end
endmodule
